// File: rtl/instruction_fetch.sv
// Fetch stage: issues one outstanding instruction-memory read per fetch and holds
// the returned word for decode; handles redirect flushes, misaligned PCs and timeouts.
module instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic [31:0] instruction_addr,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT    = 2'b10;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_count;
  logic [15:0] w_count_next;
  logic [31:0] w_addr_next;
  logic [31:0] w_instr_next;
  logic [1:0]  w_cause_next;
  logic        w_expired;
  logic        w_misaligned;

  // >= rather than == so a flush taken on the last WAIT cycle still lets DRAIN expire.
  assign w_expired    = (r_count >= LAST_COUNT);
  assign w_misaligned = (instruction_addr[1:0] != 2'b00);

  always_comb begin
    w_next_state = r_state;
    w_count_next = r_count;
    w_addr_next  = mem_addr;
    w_instr_next = instruction;
    w_cause_next = fault_cause;
    case (r_state)
      S_IDLE: begin
        if (fetch_enable && !flush) begin
          w_addr_next = instruction_addr;
          if (w_misaligned) begin
            w_next_state = S_FAULT;
            w_cause_next = CAUSE_MISALIGNED;
          end else begin
            w_next_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          w_count_next = '0;
          w_next_state = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        w_count_next = r_count + 16'd1;
        if (mem_rvalid) begin
          if (flush) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_HOLD;
            w_instr_next = mem_rdata;
          end
        end else if (flush) begin
          w_next_state = S_DRAIN;
        end else if (w_expired) begin
          w_next_state = S_FAULT;
          w_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DRAIN: begin
        w_count_next = r_count + 16'd1;
        if (mem_rvalid || w_expired) begin
          w_next_state = S_IDLE;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_next_state = S_IDLE;
        end else if (instruction_ready) begin
          if (fetch_enable) begin
            // Back-to-back fetch straight from HOLD, no IDLE bubble.
            w_addr_next = instruction_addr;
            if (w_misaligned) begin
              w_next_state = S_FAULT;
              w_cause_next = CAUSE_MISALIGNED;
            end else begin
              w_next_state = S_REQ;
            end
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        w_next_state = S_FAULT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (w_next_state == S_FAULT) begin
      w_instr_next = NOP_INSTRUCTION;
    end
  end

  // Every output is a register loaded from the next-state decision.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_count           <= '0;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      instruction       <= '0;
      instruction_pc    <= '0;
      instruction_valid <= 1'b0;
      fetch_fault       <= 1'b0;
      fault_cause       <= 2'b00;
      busy              <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      r_count           <= w_count_next;
      mem_req           <= (w_next_state == S_REQ);
      mem_addr          <= w_addr_next;
      instruction       <= w_instr_next;
      instruction_pc    <= w_addr_next;
      instruction_valid <= (w_next_state == S_HOLD) || (w_next_state == S_FAULT);
      fetch_fault       <= (w_next_state == S_FAULT);
      fault_cause       <= w_cause_next;
      busy              <= (w_next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by randomized
// transactions, each checked against expectations derived from a word-level memory model.
module tb_instruction_fetch;

  localparam int unsigned T   = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic [31:0] instruction_addr = '0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instruction_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_txn = 0;

  // Instruction memory contents, filled lazily with random words.
  logic [31:0] mem_model [logic [31:0]];

  instruction_fetch #(
    .TIMEOUT_CYCLES (T),
    .NOP_INSTRUCTION(NOP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_enable     (fetch_enable),
    .instruction_addr (instruction_addr),
    .flush            (flush),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .fetch_fault      (fetch_fault),
    .fault_cause      (fault_cause),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  function automatic logic [31:0] rand_aligned();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic check_idle(input string tag);
    check_value({tag, "_busy"}, 32'(busy), 0);
    check_value({tag, "_valid"}, 32'(instruction_valid), 0);
    check_value({tag, "_req"}, 32'(mem_req), 0);
  endtask

  task automatic clear_inputs();
    fetch_enable = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    instruction_ready = 1'b0;
  endtask

  // Asserts reset with whatever else is currently driven, then checks every output.
  task automatic do_reset();
    reset = 1'b1;
    step();
    check_value("rst_req", 32'(mem_req), 0);
    check_value("rst_addr", mem_addr, 0);
    check_value("rst_instr", instruction, 0);
    check_value("rst_pc", instruction_pc, 0);
    check_value("rst_valid", 32'(instruction_valid), 0);
    check_value("rst_fault", 32'(fetch_fault), 0);
    check_value("rst_cause", 32'(fault_cause), 0);
    check_value("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic issue(input logic [31:0] addr);
    fetch_enable = 1'b1;
    instruction_addr = addr;
    step();
    fetch_enable = 1'b0;
    instruction_addr = $urandom;
  endtask

  // Entered one cycle after a fetch was launched; optionally launches the next fetch on consume.
  task automatic serve(input logic [31:0] addr, input int rdy_dly, input int rv_wait,
                       input int hold, input bit chain, input logic [31:0] next_addr);
    logic [31:0] exp_data;
    exp_data = mem_word(addr);
    for (int i = 0; i <= rdy_dly; i++) begin
      check_value("req_high", 32'(mem_req), 1);
      check_value("req_addr", mem_addr, addr);
      check_value("req_valid", 32'(instruction_valid), 0);
      mem_ready = (i == rdy_dly);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
    end
    mem_ready = 1'b0;
    for (int i = 0; i <= rv_wait; i++) begin
      check_value("wait_req", 32'(mem_req), 0);
      check_value("wait_valid", 32'(instruction_valid), 0);
      check_value("wait_busy", 32'(busy), 1);
      mem_rvalid = (i == rv_wait);
      mem_rdata = (i == rv_wait) ? exp_data : $urandom;
      fetch_enable = 1'($urandom_range(0, 1));
      instruction_addr = $urandom;
      step();
    end
    mem_rvalid = 1'b0;
    fetch_enable = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      check_value("hold_valid", 32'(instruction_valid), 1);
      check_value("hold_data", instruction, exp_data);
      check_value("hold_pc", instruction_pc, addr);
      instruction_ready = (i == hold);
      fetch_enable = (i == hold) ? chain : 1'($urandom_range(0, 1));
      instruction_addr = (i == hold) ? next_addr : $urandom;
      mem_rvalid = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
    if (!chain) check_idle("after_consume");
    $display("txn %0d fetch addr=0x%08h data=0x%08h ready_dly=%0d rvalid_wait=%0d hold=%0d chain=%0d",
             n_txn, addr, exp_data, rdy_dly, rv_wait, hold, chain);
    n_txn++;
  endtask

  task automatic flush_req(input logic [31:0] addr, input int stall);
    issue(addr);
    for (int i = 0; i < stall; i++) begin
      check_value("freq_req", 32'(mem_req), 1);
      step();
    end
    check_value("freq_req_last", 32'(mem_req), 1);
    flush = 1'b1;
    mem_ready = 1'b0;
    step();
    flush = 1'b0;
    check_idle("freq_idle");
    $display("txn %0d flush-in-req addr=0x%08h stall=%0d", n_txn, addr, stall);
    n_txn++;
  endtask

  // Positions count WAIT/DRAIN cycles from the first one after acceptance; the stage
  // stays busy until the response or until T such cycles have elapsed.
  task automatic flush_wait(input logic [31:0] addr, input int k, input int p);
    int last;
    issue(addr);
    check_value("fwait_req", 32'(mem_req), 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    last = (p < int'(T) - 1) ? p : int'(T) - 1;
    for (int pos = 0; pos <= p; pos++) begin
      check_value("fwait_busy", 32'(busy), (pos <= last) ? 1 : 0);
      check_value("fwait_valid", 32'(instruction_valid), 0);
      flush = (pos == k) || ((pos > k) && (pos <= last) && 1'($urandom_range(0, 1)));
      fetch_enable = (pos > k) && (pos <= last) && 1'($urandom_range(0, 1));
      instruction_addr = rand_aligned();
      mem_rvalid = (pos == p);
      mem_rdata = 32'hDEADBEEF;
      step();
    end
    clear_inputs();
    check_idle("fwait_idle");
    $display("txn %0d flush-in-wait addr=0x%08h flush_pos=%0d rvalid_pos=%0d", n_txn, addr, k, p);
    n_txn++;
  endtask

  task automatic fault_noise(input logic [1:0] cause, input logic [31:0] addr);
    for (int i = 0; i < 3; i++) begin
      flush = 1'($urandom_range(0, 1));
      fetch_enable = 1'($urandom_range(0, 1));
      instruction_addr = rand_aligned();
      instruction_ready = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      step();
      check_value("fault_sticky", 32'(fetch_fault), 1);
      check_value("fault_sticky_cause", 32'(fault_cause), 32'(cause));
      check_value("fault_sticky_instr", instruction, NOP);
      check_value("fault_sticky_pc", instruction_pc, addr);
      check_value("fault_sticky_req", 32'(mem_req), 0);
    end
  endtask

  task automatic fault_expect(input string tag, input logic [1:0] cause, input logic [31:0] addr);
    check_value({tag, "_fault"}, 32'(fetch_fault), 1);
    check_value({tag, "_cause"}, 32'(fault_cause), 32'(cause));
    check_value({tag, "_instr"}, instruction, NOP);
    check_value({tag, "_pc"}, instruction_pc, addr);
    check_value({tag, "_valid"}, 32'(instruction_valid), 1);
    check_value({tag, "_busy"}, 32'(busy), 1);
    check_value({tag, "_req"}, 32'(mem_req), 0);
  endtask

  task automatic misaligned_case(input logic [31:0] addr);
    issue(addr);
    fault_expect("misal", 2'b01, addr);
    fault_noise(2'b01, addr);
    do_reset();
    $display("txn %0d misaligned addr=0x%08h", n_txn, addr);
    n_txn++;
  endtask

  task automatic timeout_case(input logic [31:0] addr);
    issue(addr);
    check_value("tmo_req", 32'(mem_req), 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int pos = 0; pos < int'(T); pos++) begin
      check_value("tmo_busy", 32'(busy), 1);
      check_value("tmo_nofault", 32'(fetch_fault), 0);
      check_value("tmo_valid", 32'(instruction_valid), 0);
      step();
    end
    fault_expect("tmo", 2'b10, addr);
    fault_noise(2'b10, addr);
    do_reset();
    $display("txn %0d timeout addr=0x%08h", n_txn, addr);
    n_txn++;
  endtask

  task automatic reset_in_flight(input logic [31:0] addr);
    issue(addr);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = $urandom;
    flush = 1'($urandom_range(0, 1));
    do_reset();
    check_idle("rif_idle");
    $display("txn %0d reset-in-flight addr=0x%08h", n_txn, addr);
    n_txn++;
  endtask

  logic [31:0] cur_addr;
  logic [31:0] nxt_addr;
  bit          chain;
  int          kind;
  int          kpos;

  initial begin
    do_reset();

    // Basic fetch, 5-cycle backpressure, then back-to-back fetch of the next word.
    mem_model[32'h00001000] = 32'h00500093;
    issue(32'h00001000);
    serve(32'h00001000, 0, 0, 5, 1'b1, 32'h00001004);
    serve(32'h00001004, 1, 2, 0, 1'b0, 32'h0);

    // Flush one cycle after acceptance; the stale response must be discarded.
    flush_wait(32'h00003000, 0, 2);
    issue(32'h00002000);
    serve(32'h00002000, 0, 1, 1, 1'b0, 32'h0);

    flush_req(32'h00004000, 0);
    misaligned_case(32'h00001002);
    timeout_case(32'h00005000);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 6);
      cur_addr = rand_aligned();
      case (kind)
        0, 1: begin
          issue(cur_addr);
          chain = 1'b1;
          while (chain) begin
            chain = ($urandom_range(0, 2) == 0);
            nxt_addr = rand_aligned();
            serve(cur_addr, $urandom_range(0, 3), $urandom_range(0, int'(T) - 1),
                  $urandom_range(0, 3), chain, nxt_addr);
            cur_addr = nxt_addr;
          end
        end
        2: flush_req(cur_addr, $urandom_range(0, 2));
        3: begin
          kpos = $urandom_range(0, int'(T) - 2);
          flush_wait(cur_addr, kpos, kpos + int'($urandom_range(0, T)));
        end
        4: timeout_case(cur_addr);
        5: begin
          cur_addr[1:0] = 2'($urandom_range(1, 3));
          misaligned_case(cur_addr);
        end
        default: reset_in_flight(cur_addr);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
